// File: rtl/pwm_capture.sv
// PWM receiver: reports period and high time (in clk cycles) of an async PWM input.
// Optional glitch filter on the synchronised input, enabled by defining PWM_CAP_FILTER_EN.
module pwm_capture #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned TIMEOUT  = 32'd50_000_000,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             stuck_level,
  output logic             locked
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [WIDTH-1:0] TO_W = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
`ifdef PWM_CAP_FILTER_EN
  localparam logic [2:0] WARM_DONE = 3'd4;
`else
  localparam logic [2:0] WARM_DONE = 3'd3;
`endif

  logic             s1_q, s2_q, lvl_q, lvl;
  logic [2:0]       warm_q;
  logic             armed, rise, fall;
  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] cnt_to_q, cnt_to_d, to_inc;
  logic             to_hit;
  state_t           state_q;
  logic [WIDTH-1:0] hi_lat_q, period_q, high_q;
  logic             valid_q, timeout_q, stuck_q, locked_q;

  // The pipeline flops reset to 0, so edges stay masked until they hold real input samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      warm_q <= '0;
    end else begin
      s1_q  <= pwm_in;
      s2_q  <= s1_q;
      lvl_q <= lvl;
      if (warm_q != WARM_DONE) warm_q <= warm_q + 3'd1;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int unsigned FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

  logic          filt_q;
  logic [FW-1:0] fcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (warm_q != WARM_DONE) begin
      filt_q <= s2_q;
      fcnt_q <= '0;
    end else if (s2_q != filt_q) begin
      if (fcnt_q == FW'(FILT_LEN - 1)) begin
        filt_q <= s2_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FW'(1);
      end
    end else begin
      fcnt_q <= '0;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif

  always_comb begin
    armed = (warm_q == WARM_DONE);
    rise  = armed &  lvl & ~lvl_q;
    fall  = armed & ~lvl &  lvl_q;
  end

  always_comb begin
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + ONE;
    cnt_d    = rise ? ONE : cnt_inc;
    to_inc   = (cnt_to_q == '1) ? cnt_to_q : cnt_to_q + ONE;
    cnt_to_d = (rise | fall) ? '0 : to_inc;
    // Fires once as the counter passes TIMEOUT; it then keeps counting, so no repeat.
    to_hit   = ~(rise | fall) & (to_inc == TO_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      cnt_to_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      cnt_to_q <= cnt_to_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hi_lat_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      stuck_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      if (to_hit) begin
        timeout_q <= 1'b1;
        stuck_q   <= lvl;
        locked_q  <= 1'b0;
        state_q   <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (rise) state_q <= HIGH;
          HIGH: if (fall) begin
            hi_lat_q <= cnt_q;
            state_q  <= LOW;
          end
          LOW: if (rise) begin
            period_q <= cnt_q;
            high_q   <= hi_lat_q;
            valid_q  <= 1'b1;
            locked_q <= 1'b1;
            state_q  <= HIGH;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign period      = period_q;
  assign high_time   = high_q;
  assign meas_valid  = valid_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: loopback, reset, timeout, rate change, glitch, saturation.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst, pwm_in, pwm_sat;
  logic [31:0] period, high_time;
  logic        meas_valid, timeout, stuck_level, locked;
  logic [7:0]  s_period, s_high;
  logic        s_mv, s_to, s_stuck, s_locked;

  int checks = 0;
  int passed = 0;
  int unsigned cyc = 0;

  int unsigned mv_per[$], mv_hi[$], mv_cyc[$], to_cyc[$];
  bit          mv_lck[$], to_lvl[$];
  int unsigned s_per[$], s_hi[$];
  int          s_to_n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_capture #(.WIDTH(32), .TIMEOUT(100), .FILT_LEN(3)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .timeout(timeout), .stuck_level(stuck_level), .locked(locked)
  );

  pwm_capture #(.WIDTH(8), .TIMEOUT(254), .FILT_LEN(3)) u_sat (
    .clk(clk), .rst(rst), .pwm_in(pwm_sat),
    .period(s_period), .high_time(s_high), .meas_valid(s_mv),
    .timeout(s_to), .stuck_level(s_stuck), .locked(s_locked)
  );

  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      mv_per.push_back(period);
      mv_hi.push_back(high_time);
      mv_cyc.push_back(cyc);
      mv_lck.push_back(locked);
    end
    if (timeout === 1'b1) begin
      to_cyc.push_back(cyc);
      to_lvl.push_back(stuck_level);
    end
    if (s_mv === 1'b1) begin
      s_per.push_back(s_period);
      s_hi.push_back(s_high);
    end
    if (s_to === 1'b1) s_to_n++;
  end

  task automatic clear_q();
    #1;
    mv_per.delete(); mv_hi.delete(); mv_cyc.delete(); mv_lck.delete();
    to_cyc.delete(); to_lvl.delete(); s_per.delete(); s_hi.delete();
    s_to_n = 0;
  endtask

  task automatic drive(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic sdrive(input logic lvl, input int n);
    pwm_sat = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic period_drv(input int hi, input int per);
    drive(1'b1, hi);
    drive(1'b0, per - hi);
  endtask

  task automatic test_reset();
    rst = 1'b1; pwm_in = 1'b0; pwm_sat = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({period, high_time} !== 64'd0) $display("FAIL rst_meas: got %0d/%0d expected 0/0", period, high_time); else passed++;
    checks++; if ({meas_valid, timeout} !== 2'b00) $display("FAIL rst_pulses: got %b%b expected 00", meas_valid, timeout); else passed++;
    checks++; if ({stuck_level, locked} !== 2'b00) $display("FAIL rst_flags: got %b%b expected 00", stuck_level, locked); else passed++;
    rst = 1'b0;
    clear_q();
    repeat (10) @(negedge clk);
    checks++; if (mv_per.size() + to_cyc.size() !== 0) $display("FAIL rst_quiet: got %0d pulses expected 0", mv_per.size() + to_cyc.size()); else passed++;
  endtask

  task automatic test_loopback();
    clear_q();
    repeat (5) period_drv(3, 10);
    checks++; if (mv_per.size() !== 4) $display("FAIL loop_count: got %0d expected 4", mv_per.size()); else passed++;
    for (int i = 0; i < mv_per.size(); i++) begin
      checks++; if (mv_per[i] !== 10) $display("FAIL loop_period[%0d]: got %0d expected 10", i, mv_per[i]); else passed++;
      checks++; if (mv_hi[i] !== 3) $display("FAIL loop_high[%0d]: got %0d expected 3", i, mv_hi[i]); else passed++;
      checks++; if (mv_lck[i] !== 1'b1) $display("FAIL loop_locked[%0d]: got %b expected 1", i, mv_lck[i]); else passed++;
      if (i > 0) begin
        checks++;
        if (mv_cyc[i] - mv_cyc[i-1] !== 10) $display("FAIL loop_spacing[%0d]: got %0d expected 10", i, mv_cyc[i] - mv_cyc[i-1]);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_high();
    pwm_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({period, high_time} !== 64'd0) $display("FAIL midrst_meas: got %0d/%0d expected 0/0", period, high_time); else passed++;
    checks++; if ({meas_valid, timeout, stuck_level, locked} !== 4'b0000) $display("FAIL midrst_flags: got %b%b%b%b expected 0000", meas_valid, timeout, stuck_level, locked); else passed++;
    rst = 1'b0;
    clear_q();
    drive(1'b1, 4);
    drive(1'b0, 13);
    repeat (3) period_drv(7, 20);
    checks++; if (mv_per.size() !== 2) $display("FAIL midrst_count: got %0d expected 2", mv_per.size()); else passed++;
    for (int i = 0; i < mv_per.size(); i++) begin
      checks++; if (mv_per[i] !== 20) $display("FAIL midrst_period[%0d]: got %0d expected 20", i, mv_per[i]); else passed++;
      checks++; if (mv_hi[i] !== 7) $display("FAIL midrst_high[%0d]: got %0d expected 7", i, mv_hi[i]); else passed++;
    end
  endtask

  task automatic test_timeout();
    clear_q();
    drive(1'b1, 200);
    checks++; if (mv_per.size() !== 1) $display("FAIL to_mv_count: got %0d expected 1", mv_per.size()); else passed++;
    checks++; if (to_cyc.size() !== 1) $display("FAIL to_count: got %0d expected 1", to_cyc.size()); else passed++;
    if (mv_cyc.size() == 1 && to_cyc.size() == 1) begin
      checks++;
      if (to_cyc[0] - mv_cyc[0] !== 100) $display("FAIL to_delay: got %0d expected 100", to_cyc[0] - mv_cyc[0]);
      else passed++;
      checks++; if (to_lvl[0] !== 1'b1) $display("FAIL to_stuck_at_pulse: got %b expected 1", to_lvl[0]); else passed++;
    end
    checks++; if (stuck_level !== 1'b1) $display("FAIL to_stuck: got %b expected 1", stuck_level); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL to_locked: got %b expected 0", locked); else passed++;
    checks++; if (period !== 32'd20) $display("FAIL to_period_hold: got %0d expected 20", period); else passed++;
    checks++; if (high_time !== 32'd7) $display("FAIL to_high_hold: got %0d expected 7", high_time); else passed++;
  endtask

  task automatic test_on_the_fly();
    int unsigned ep[4] = '{10, 10, 16, 16};
    int unsigned eh[4] = '{3, 3, 11, 11};
    clear_q();
    drive(1'b0, 7);
    repeat (2) period_drv(3, 10);
    repeat (3) period_drv(11, 16);
    drive(1'b0, 5);
    checks++; if (mv_per.size() !== 4) $display("FAIL fly_count: got %0d expected 4", mv_per.size()); else passed++;
    checks++; if (to_cyc.size() !== 0) $display("FAIL fly_timeout: got %0d expected 0", to_cyc.size()); else passed++;
    for (int i = 0; i < mv_per.size() && i < 4; i++) begin
      checks++;
      if (mv_per[i] !== ep[i] || mv_hi[i] !== eh[i])
        $display("FAIL fly_pair[%0d]: got %0d/%0d expected %0d/%0d", i, mv_per[i], mv_hi[i], ep[i], eh[i]);
      else passed++;
    end
  endtask

  task automatic test_glitch();
    int ng;
    int unsigned ep, eh;
    pwm_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 8);
    clear_q();
    repeat (4) begin
      drive(1'b1, 5);
      drive(1'b0, 2);
      drive(1'b1, 5);
      drive(1'b0, 18);
    end
    drive(1'b0, 10);
`ifdef PWM_CAP_FILTER_EN
    ng = 3;
`else
    ng = 7;
`endif
    checks++; if (mv_per.size() !== ng) $display("FAIL glitch_count: got %0d expected %0d", mv_per.size(), ng); else passed++;
    for (int i = 0; i < mv_per.size() && i < ng; i++) begin
`ifdef PWM_CAP_FILTER_EN
      ep = 30; eh = 12;
`else
      ep = (i % 2 == 0) ? 7 : 23; eh = 5;
`endif
      checks++;
      if (mv_per[i] !== ep || mv_hi[i] !== eh)
        $display("FAIL glitch_pair[%0d]: got %0d/%0d expected %0d/%0d", i, mv_per[i], mv_hi[i], ep, eh);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    sdrive(1'b0, 300);
    clear_q();
    repeat (4) begin
      sdrive(1'b1, 150);
      sdrive(1'b0, 150);
    end
    sdrive(1'b0, 150);
    checks++; if (s_per.size() !== 3) $display("FAIL sat_count: got %0d expected 3", s_per.size()); else passed++;
    for (int i = 0; i < s_per.size(); i++) begin
      checks++; if (s_per[i] !== 255) $display("FAIL sat_period[%0d]: got %0d expected 255", i, s_per[i]); else passed++;
      checks++; if (s_hi[i] !== 150) $display("FAIL sat_high[%0d]: got %0d expected 150", i, s_hi[i]); else passed++;
    end
    checks++; if (s_to_n !== 1) $display("FAIL sat_timeouts: got %0d expected 1", s_to_n); else passed++;
    checks++; if ({s_stuck, s_locked} !== 2'b00) $display("FAIL sat_flags: got %b%b expected 00", s_stuck, s_locked); else passed++;
    checks++; if (s_period !== 8'd255) $display("FAIL sat_hold: got %0d expected 255", s_period); else passed++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_reset_mid_high();
    test_timeout();
    test_on_the_fly();
    test_glitch();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
